// File: rtl/ps2_scan_decoder.sv
// ps2_scan_decoder: PS/2 keyboard frame receiver and scan-code filter.
// Optional break-code reporting is enabled with `define PS2_BREAK_REPORT_EN.
module ps2_scan_decoder #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 20000,
    parameter int TW         = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2c,
    input  logic       ps2d,
    output logic [7:0] Cambio,
    output logic       got_data,
    output logic       extended,
    output logic       frame_err,
    output logic       released
);

    localparam int FW = $clog2(FILTER_LEN + 1);

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        PARITY,
        STOP,
        CHECK
    } state_t;

    logic [1:0]    c_sync;
    logic [1:0]    d_sync;
    logic          c_filt;
    logic          d_filt;
    logic [FW-1:0] c_cnt;
    logic [FW-1:0] d_cnt;
    logic          fall;

    state_t        state;
    logic [7:0]    shreg;
    logic [2:0]    bcnt;
    logic          par;
    logic          stp;
    logic [TW-1:0] tcnt;
    logic          brk;
    logic          ext;
    logic          valid;

    // Two-flop synchronisers for the asynchronous pins, idle-high.
    always_ff @(posedge clk) begin
        if (rst) begin
            c_sync <= 2'b11;
            d_sync <= 2'b11;
        end else begin
            c_sync <= {c_sync[0], ps2c};
            d_sync <= {d_sync[0], ps2d};
        end
    end

    // Clock glitch filter; emits a one-cycle pulse on an accepted 1->0.
    always_ff @(posedge clk) begin
        if (rst) begin
            c_filt <= 1'b1;
            c_cnt  <= '0;
            fall   <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (c_sync[1] != c_filt) begin
                if (c_cnt == FW'(FILTER_LEN - 1)) begin
                    c_filt <= c_sync[1];
                    c_cnt  <= '0;
                    fall   <= c_filt;
                end else begin
                    c_cnt <= c_cnt + 1'b1;
                end
            end else begin
                c_cnt <= '0;
            end
        end
    end

    // Data glitch filter, same delay as the clock path.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_filt <= 1'b1;
            d_cnt  <= '0;
        end else begin
            if (d_sync[1] != d_filt) begin
                if (d_cnt == FW'(FILTER_LEN - 1)) begin
                    d_filt <= d_sync[1];
                    d_cnt  <= '0;
                end else begin
                    d_cnt <= d_cnt + 1'b1;
                end
            end else begin
                d_cnt <= '0;
            end
        end
    end

    // Odd parity over data plus parity bit, and a high stop bit.
    assign valid = (^{shreg, par}) && stp;

    // Frame FSM, timeout, prefix handling and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            bcnt      <= '0;
            par       <= 1'b0;
            stp       <= 1'b0;
            tcnt      <= '0;
            brk       <= 1'b0;
            ext       <= 1'b0;
            Cambio    <= 8'h00;
            got_data  <= 1'b0;
            extended  <= 1'b0;
            frame_err <= 1'b0;
`ifdef PS2_BREAK_REPORT_EN
            released  <= 1'b0;
`endif
        end else begin
            got_data  <= 1'b0;
            frame_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (fall && !d_filt) begin
                        state <= RECV;
                        bcnt  <= '0;
                        tcnt  <= '0;
                    end
                end
                RECV, PARITY, STOP: begin
                    if (fall) begin
                        tcnt <= '0;
                        if (state == RECV) begin
                            shreg <= {d_filt, shreg[7:1]};
                            bcnt  <= bcnt + 1'b1;
                            if (bcnt == 3'd7) begin
                                state <= PARITY;
                            end
                        end else if (state == PARITY) begin
                            par   <= d_filt;
                            state <= STOP;
                        end else begin
                            stp   <= d_filt;
                            state <= CHECK;
                        end
                    end else if (tcnt == TW'(TIMEOUT)) begin
                        frame_err <= 1'b1;
                        shreg     <= '0;
                        brk       <= 1'b0;
                        ext       <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                CHECK: begin
                    state <= IDLE;
                    if (!valid) begin
                        frame_err <= 1'b1;
                        brk       <= 1'b0;
                        ext       <= 1'b0;
                    end else if (shreg == 8'hE0) begin
                        ext <= 1'b1;
                    end else if (shreg == 8'hF0) begin
                        brk <= 1'b1;
                    end else if (brk) begin
`ifdef PS2_BREAK_REPORT_EN
                        Cambio   <= shreg;
                        extended <= ext;
                        got_data <= 1'b1;
                        released <= 1'b1;
`endif
                        brk <= 1'b0;
                        ext <= 1'b0;
                    end else begin
                        Cambio   <= shreg;
                        extended <= ext;
                        got_data <= 1'b1;
`ifdef PS2_BREAK_REPORT_EN
                        released <= 1'b0;
`endif
                        ext <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef PS2_BREAK_REPORT_EN
    assign released = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// tb_ps2_scan_decoder: randomized PS/2 frames against a byte-level
// reference model of prefix/break handling.
`timescale 1ns/1ps
module tb_ps2_scan_decoder;

    localparam int TIMEOUT = 20000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2c = 1'b1;
    logic       ps2d = 1'b1;
    logic [7:0] Cambio;
    logic       got_data;
    logic       extended;
    logic       frame_err;
    logic       released;

    int checks = 0;
    int failures = 0;

    logic [9:0] obs_q[$];
    logic [9:0] exp_q[$];
    int         err_obs = 0;
    int         err_exp = 0;
    int         merges = 0;
    logic       prev_gd = 1'b0;

    bit         m_ext = 0;
    bit         m_brk = 0;
    logic [7:0] last_code = 8'h00;

    ps2_scan_decoder #(
        .FILTER_LEN(8),
        .TIMEOUT(TIMEOUT),
        .TW(15)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ps2c(ps2c),
        .ps2d(ps2d),
        .Cambio(Cambio),
        .got_data(got_data),
        .extended(extended),
        .frame_err(frame_err),
        .released(released)
    );

    // 1 MHz system clock: one PS/2 bit of 60 us is 60 cycles.
    always #500 clk = ~clk;

    // Record every strobe and error pulse away from the active edge.
    always @(negedge clk) begin
        if (got_data) obs_q.push_back({released, extended, Cambio});
        if (frame_err) err_obs++;
        if (got_data && prev_gd) merges++;
        prev_gd = got_data;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
    endtask

    // Send bits[0..nbits-1] of an 11-bit frame at a 60-cycle bit period.
    task automatic send_bits(input logic [10:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            ps2d = bits[i];
            wait_cyc(15);
            ps2c = 1'b0;
            wait_cyc(30);
            ps2c = 1'b1;
            wait_cyc(15);
        end
        ps2d = 1'b1;
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b,
                                             input bit bad_par);
        logic p;
        p = ~(^b) ^ bad_par;
        return {1'b1, p, b, 1'b0};
    endfunction

    // Byte-level reference: what the keyboard stream means.
    task automatic model_byte(input logic [7:0] b, input bit ok);
        if (!ok) begin
            err_exp++;
            m_ext = 0;
            m_brk = 0;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else begin
            if (!m_brk) begin
                exp_q.push_back({1'b0, m_ext, b});
                last_code = b;
            end
`ifdef PS2_BREAK_REPORT_EN
            else begin
                exp_q.push_back({1'b1, m_ext, b});
                last_code = b;
            end
`endif
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par);
        send_bits(mk_frame(b, bad_par), 11);
        model_byte(b, !bad_par);
    endtask

    task automatic clear_obs;
        obs_q.delete();
        exp_q.delete();
        err_obs = 0;
        err_exp = 0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        wait_cyc(5);
        @(negedge clk);
        checks++;
        if (Cambio !== 8'h00) begin
            failures++;
            $display("FAIL reset_cambio got=%h exp=00", Cambio);
        end
        checks++;
        if (got_data !== 1'b0 || frame_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_pulses got=%b%b exp=00", got_data, frame_err);
        end
        checks++;
        if (extended !== 1'b0 || released !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b%b exp=00", extended, released);
        end
        rst = 1'b0;
        wait_cyc(20);
        clear_obs();
    endtask

    task automatic test_single_make;
        clear_obs();
        send_frame(8'h73, 0);
        wait_cyc(40);
        checks++;
        if (obs_q.size() !== 1) begin
            failures++;
            $display("FAIL single_count got=%0d exp=1", obs_q.size());
        end else begin
            checks++;
            if (obs_q[0] !== 10'h073) begin
                failures++;
                $display("FAIL single_code got=%h exp=073", obs_q[0]);
            end
        end
        checks++;
        if (err_obs !== 0) begin
            failures++;
            $display("FAIL single_err got=%0d exp=0", err_obs);
        end
    endtask

    task automatic test_ext_break;
        clear_obs();
        send_frame(8'hE0, 0);
        send_frame(8'h72, 0);
        send_frame(8'hE0, 0);
        send_frame(8'hF0, 0);
        send_frame(8'h72, 0);
        wait_cyc(40);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL extbrk_count got=%0d exp=%0d",
                     obs_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL extbrk_code[%0d] got=%h exp=%h",
                             i, obs_q[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (extended !== 1'b1) begin
            failures++;
            $display("FAIL extbrk_extended got=%b exp=1", extended);
        end
    endtask

    task automatic test_bad_parity;
        clear_obs();
        send_frame(8'h7D, 1);
        wait_cyc(40);
        checks++;
        if (err_obs !== 1) begin
            failures++;
            $display("FAIL parity_err got=%0d exp=1", err_obs);
        end
        checks++;
        if (obs_q.size() !== 0) begin
            failures++;
            $display("FAIL parity_strobe got=%0d exp=0", obs_q.size());
        end
        checks++;
        if (Cambio !== last_code) begin
            failures++;
            $display("FAIL parity_hold got=%h exp=%h", Cambio, last_code);
        end
    endtask

    task automatic test_timeout;
        clear_obs();
        send_bits(mk_frame(8'h73, 0), 5);
        wait_cyc(TIMEOUT + 10);
        model_byte(8'h00, 0);
        checks++;
        if (err_obs !== 1) begin
            failures++;
            $display("FAIL timeout_err got=%0d exp=1", err_obs);
        end
        send_frame(8'h73, 0);
        wait_cyc(40);
        checks++;
        if (obs_q.size() !== 1) begin
            failures++;
            $display("FAIL timeout_count got=%0d exp=1", obs_q.size());
        end else begin
            checks++;
            if (obs_q[0] !== exp_q[0]) begin
                failures++;
                $display("FAIL timeout_code got=%h exp=%h", obs_q[0], exp_q[0]);
            end
        end
        checks++;
        if (err_obs !== err_exp) begin
            failures++;
            $display("FAIL timeout_errtotal got=%0d exp=%0d", err_obs, err_exp);
        end
    endtask

    task automatic test_glitch_reset;
        clear_obs();
        ps2d = 1'b0;
        wait_cyc(2);
        ps2c = 1'b0;
        wait_cyc(3);
        ps2c = 1'b1;
        wait_cyc(2);
        ps2d = 1'b1;
        wait_cyc(30);
        send_frame(8'h73, 0);
        wait_cyc(40);
        checks++;
        if (obs_q.size() !== 1 || err_obs !== 0) begin
            failures++;
            $display("FAIL glitch_frame got=%0d/%0d exp=1/0",
                     obs_q.size(), err_obs);
        end
        clear_obs();
        send_bits(mk_frame(8'h72, 0), 4);
        rst = 1'b1;
        wait_cyc(3);
        @(negedge clk);
        checks++;
        if ({Cambio, got_data, extended, frame_err, released} !== 12'h000) begin
            failures++;
            $display("FAIL midreset_outputs got=%h exp=000",
                     {Cambio, got_data, extended, frame_err, released});
        end
        rst = 1'b0;
        m_ext = 0;
        m_brk = 0;
        last_code = 8'h00;
        wait_cyc(20);
        send_frame(8'h72, 0);
        wait_cyc(40);
        checks++;
        if (obs_q.size() !== 1 || err_obs !== 0) begin
            failures++;
            $display("FAIL midreset_count got=%0d/%0d exp=1/0",
                     obs_q.size(), err_obs);
        end else begin
            checks++;
            if (obs_q[0] !== 10'h072) begin
                failures++;
                $display("FAIL midreset_code got=%h exp=072", obs_q[0]);
            end
        end
    endtask

    task automatic test_back_to_back;
        clear_obs();
        merges = 0;
        for (int i = 0; i < 3; i++) send_frame(8'h73, 0);
        wait_cyc(40);
        checks++;
        if (obs_q.size() !== 3) begin
            failures++;
            $display("FAIL b2b_count got=%0d exp=3", obs_q.size());
        end
        checks++;
        if (merges !== 0) begin
            failures++;
            $display("FAIL b2b_merge got=%0d exp=0", merges);
        end
    endtask

    task automatic test_random;
        logic [7:0] b;
        int         sel;
        bit         bad;
        clear_obs();
        merges = 0;
        for (int n = 0; n < 25; n++) begin
            sel = $urandom_range(0, 5);
            if (sel == 0) b = 8'hE0;
            else if (sel == 1) b = 8'hF0;
            else b = 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 7) == 0);
            send_frame(b, bad);
            wait_cyc($urandom_range(0, 30));
        end
        wait_cyc(40);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL rand_count got=%0d exp=%0d",
                     obs_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL rand_code[%0d] got=%h exp=%h",
                             i, obs_q[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (err_obs !== err_exp) begin
            failures++;
            $display("FAIL rand_err got=%0d exp=%0d", err_obs, err_exp);
        end
        checks++;
        if (merges !== 0) begin
            failures++;
            $display("FAIL rand_merge got=%0d exp=0", merges);
        end
    endtask

    initial begin
        test_reset();
        test_single_make();
        test_ext_break();
        test_bad_parity();
        test_timeout();
        test_glitch_reset();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
